// File: rtl/alu_op_issue.sv
// ALU operation issue stage: decodes RISC-V fields into ALU op/src-select
// and buffers them in a main+skid pair behind a valid/ready handshake.
module alu_op_issue #(
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     alu_src_imm,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_SLT = 4'b1100;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                     is_r, is_i, is_ls, is_br, is_jmp;
  logic [3:0]               dop;
  logic                     dimm;
  logic                     dill;
  logic                     f7z;

  logic                     mv, sv;
  logic [OPCODE_LENGTH-1:0] sop;
  logic                     simm, sill;
  logic                     acc, emit;

  assign is_r   = opcode == 7'b0110011;
  assign is_i   = opcode == 7'b0010011;
  assign is_ls  = (opcode == 7'b0000011) | (opcode == 7'b0100011);
  assign is_br  = opcode == 7'b1100011;
  assign is_jmp = (opcode == 7'b1101111) | (opcode == 7'b1100111)
                | (opcode == 7'b0110111) | (opcode == 7'b0010111);
  assign f7z    = funct7 == 7'b0000000;

  always_comb begin
    dop  = OP_AND;
    dimm = 1'b0;
    dill = 1'b0;
    unique case (1'b1)
      is_r: begin
        if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
          dop = OP_SUB;
        end else if (!f7z) begin
          dill = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dop = OP_ADD;
            3'b111:  dop = OP_AND;
            3'b110:  dop = OP_OR;
            3'b100:  dop = OP_XOR;
            3'b010:  dop = OP_SLT;
            default: dill = 1'b1;
          endcase
        end
      end
      is_i: begin
        dimm = 1'b1;
        case (funct3)
          3'b000:  dop = OP_ADD;
          3'b111:  dop = OP_AND;
          3'b110:  dop = OP_OR;
          3'b100:  dop = OP_XOR;
          3'b010:  dop = OP_SLT;
          default: dill = 1'b1;
        endcase
      end
      is_ls, is_jmp: begin
        dop  = OP_ADD;
        dimm = 1'b1;
      end
      is_br: begin
        if (funct3 == 3'b000) dop = OP_EQ;
        else dill = 1'b1;
      end
      default: dill = 1'b1;
    endcase
    // Illegal entries always present a neutral op and rs2 select.
    if (dill) begin
      dop  = OP_AND;
      dimm = 1'b0;
    end
  end

  assign in_ready  = ~sv;
  assign out_valid = mv;
  assign acc       = in_valid & ~sv;
  assign emit      = mv & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      mv            <= 1'b0;
      sv            <= 1'b0;
      Operation     <= '0;
      alu_src_imm   <= 1'b0;
      illegal       <= 1'b0;
      sop           <= '0;
      simm          <= 1'b0;
      sill          <= 1'b0;
      illegal_count <= '0;
    end else begin
      if (emit && illegal && illegal_count != CNT_MAX)
        illegal_count <= illegal_count + 1'b1;
      if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (!mv || emit) begin
        if (sv) begin
          Operation   <= sop;
          alu_src_imm <= simm;
          illegal     <= sill;
          mv          <= 1'b1;
          sv          <= acc;
          if (acc) begin
            sop  <= OPCODE_LENGTH'(dop);
            simm <= dimm;
            sill <= dill;
          end
        end else begin
          mv <= acc;
          if (acc) begin
            Operation   <= OPCODE_LENGTH'(dop);
            alu_src_imm <= dimm;
            illegal     <= dill;
          end
        end
      end else if (acc) begin
        sop  <= OPCODE_LENGTH'(dop);
        simm <= dimm;
        sill <= dill;
        sv   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode, skid ordering, saturation,
// flush and reset behaviour.
module tb_alu_op_issue;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid, in_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       out_valid, out_ready;
  logic [3:0] Operation;
  logic       alu_src_imm, illegal;
  logic [1:0] illegal_count;

  int compared = 0;
  int mismatched = 0;

  alu_op_issue #(.OPCODE_LENGTH(4), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .alu_src_imm(alu_src_imm),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7);
    in_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [3:0] op, input logic imm,
                         input logic ill);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_op"}, 32'(Operation), 32'(op));
    chk({tag, "_imm"}, 32'(alu_src_imm), 32'(imm));
    chk({tag, "_ill"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    step();
    chk_out("rst", 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(illegal_count), 32'd0);
    reset = 1'b0;

    // SUB
    drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
    step();
    chk_out("sub", 1'b1, 4'b0011, 1'b0, 1'b0);

    // ADDI, BEQ, LW back to back
    drive(1'b1, 7'b0010011, 3'b000, 7'd0);
    step();
    chk_out("addi", 1'b1, 4'b0010, 1'b1, 1'b0);
    chk("addi_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 7'b1100011, 3'b000, 7'd0);
    step();
    chk_out("beq", 1'b1, 4'b1000, 1'b0, 1'b0);
    chk("beq_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 7'b0000011, 3'b010, 7'd0);
    step();
    chk_out("lw", 1'b1, 4'b0010, 1'b1, 1'b0);
    chk("lw_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Stall: XOR then SLTI
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b100, 7'd0);
    step();
    chk_out("xor", 1'b1, 4'b1001, 1'b0, 1'b0);
    chk("xor_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 7'b0010011, 3'b010, 7'd0);
    step();
    chk("stall_op", 32'(Operation), 32'b1001);
    chk("stall_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    chk("hold_op", 32'(Operation), 32'b1001);
    chk("hold_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk_out("slti", 1'b1, 4'b1100, 1'b1, 1'b0);
    chk("slti_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Illegal encodings
    drive(1'b1, 7'b1110011, 3'b000, 7'd0);
    step();
    chk_out("sys", 1'b1, 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 7'b0110011, 3'b001, 7'd0);
    step();
    chk_out("sll", 1'b1, 4'b0000, 1'b0, 1'b1);
    chk("cnt1", 32'(illegal_count), 32'd1);
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    chk("cnt2", 32'(illegal_count), 32'd2);

    // Saturation with a 2-bit counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'b1111111, 3'b000, 7'd0);
    step();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) drive(1'b0, 7'd0, 3'd0, 7'd0);
      step();
      chk($sformatf("sat%0d", k), 32'(illegal_count),
          (k > 3) ? 32'd3 : 32'(k));
    end

    // Flush with two entries buffered
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b1, 7'b0110011, 3'b011, 7'd0);
    step();
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    chk("pre_flush_cnt", 32'(illegal_count), 32'd1);
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b101, 7'd0);
    step();
    drive(1'b1, 7'b1100011, 3'b001, 7'd0);
    step();
    chk("fl_ready0", 32'(in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 7'b0010011, 3'b000, 7'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_cnt", 32'(illegal_count), 32'd1);
    out_ready = 1'b1;
    step();
    chk("fl_drop", 32'(out_valid), 32'd0);
    chk("fl_cnt2", 32'(illegal_count), 32'd1);

    // Reset mid-stall
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b110, 7'd0);
    step();
    drive(1'b1, 7'b1111111, 3'b000, 7'd0);
    step();
    chk("rs_ready0", 32'(in_ready), 32'd0);
    reset = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    step();
    chk_out("rs", 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rs_ready", 32'(in_ready), 32'd1);
    chk("rs_cnt", 32'(illegal_count), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rs_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- Issue stage that turns decoded RISC-V instruction fields into the 4-bit ALU Operation code and operand-select the ALU consumes.
- Sits between the instruction decoder and the ALU/execute stage.
- Registered output with valid/ready handshake and a 2-entry skid buffer, so execute back-pressure never drops an instruction.
- Flags unsupported encodings and keeps a saturating count of them.

Parameters:
- OPCODE_LENGTH, 4, width of the Operation output.
- CNT_WIDTH, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock, all state updates on its rising edge.
- reset  input  1  synchronous active-high reset.
- flush  input  1  discard all buffered entries (branch redirect).
- in_valid  input  1  decoder presents fields this cycle.
- in_ready  output  1  block can accept a new entry.
- opcode  input  7  instruction opcode [6:0].
- funct3  input  3  instruction funct3.
- funct7  input  7  instruction funct7.
- out_valid  output  1  Operation/alu_src_imm/illegal are valid.
- out_ready  input  1  execute stage accepts the output.
- Operation  output  OPCODE_LENGTH  ALU operation code.
- alu_src_imm  output  1  1 = SrcB from immediate, 0 = from rs2.
- illegal  output  1  unsupported encoding; Operation forced to 0000.
- illegal_count  output  CNT_WIDTH  saturating count of illegal entries issued.

Behaviour:
- Operation encoding: AND 0000, OR 0001, ADD 0010, SUB 0011, EQ 1000, XOR 1001, SLT 1100.
- Decode, R-type (opcode 0110011, alu_src_imm=0):
  - f3=000 with f7=0000000 -> ADD; with f7=0100000 -> SUB.
  - f3=111 -> AND, 110 -> OR, 100 -> XOR, 010 -> SLT; each requires f7=0000000.
  - Any other f3/f7 pair is illegal.
- Decode, I-ALU (0010011, imm=1): f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; other f3 illegal; funct7 ignored.
- Decode, load (0000011) / store (0100011): ADD, imm=1, any funct3.
- Decode, branch (1100011): f3=000 -> EQ, imm=0; other f3 illegal.
- Decode, JAL (1101111), JALR (1100111), LUI (0110111), AUIPC (0010111): ADD, imm=1.
- Any other opcode: illegal=1, Operation=0000, alu_src_imm=0.
- Buffer: main register (drives outputs) plus skid register. Fields are decoded before storage.
- Accept on in_valid & in_ready. Emit on out_valid & out_ready.
- Latency: an entry accepted into an empty block appears on the outputs the next cycle.
- in_ready = skid register empty; it is a registered value, not combinationally dependent on out_ready.
- Main empty, or main emitting this cycle:
  - New entry goes to main.
  - If the skid register is occupied, skid moves to main and the new entry goes to skid. Order is preserved.
- Main holding and not emitting: new entry goes to skid. in_ready drops the next cycle.
- Simultaneous accept and emit with one entry held: throughput stays at 1 per cycle and in_ready stays 1.
- While out_valid=1 and out_ready=0: Operation, alu_src_imm and illegal hold stable.
- illegal_count increments by 1 when an entry with illegal=1 is emitted (out_valid & out_ready & illegal). It saturates at 2^CNT_WIDTH-1 and never wraps.
- flush=1: both entries are invalidated at the edge. Any accept in the same cycle is discarded. out_valid=0 and in_ready=1 the next cycle. illegal_count is not changed by flush, except for an emit completed in that same cycle, which still counts.
- reset=1 at the edge has priority over flush and over any handshake, including mid-transfer:
  - out_valid=0, in_ready=1.
  - Operation=0000, alu_src_imm=0, illegal=0, illegal_count=0.
  - Skid register empty.

Test Plan:
- Reset, then in_valid with opcode 0110011, f3 000, f7 0100000, out_ready=1 -> next cycle out_valid=1, Operation=0011, alu_src_imm=0, illegal=0.
- Back-to-back ADDI, BEQ (1100011/000), LW (0000011/010), out_ready=1 -> outputs on consecutive cycles: 0010/imm1, 1000/imm0, 0010/imm1; in_ready stays 1 throughout.
- out_ready=0 while issuing XOR (R, f3 100) then SLTI (0010011, f3 010):
  - Operation holds 1001; in_ready=0 from the cycle after the second accept.
  - Raise out_ready: outputs 1001 then 1100, no loss or duplication.
- Opcode 1110011, then R-type f3 001 (SLL), both emitted -> illegal=1 and Operation=0000 for each; illegal_count=2.
- With CNT_WIDTH=2, emit 5 illegal entries -> illegal_count reads 1, 2, 3, 3, 3.
- Two entries buffered under stall, assert flush with in_valid=1 for one cycle -> next cycle out_valid=0, in_ready=1, illegal_count unchanged.
- Assert reset mid-stall -> next cycle all outputs at their reset values.
